// File: rtl/i4004_pkg.sv
// Shared types and constants for the i4004 digit-serial adder.
// Holds the sequencer state encoding, the BCD constants and the
// digit-counter sizing helper used by the top level.
package i4004_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int BCD_MAX = 9;
   localparam int BCD_ADJ = 6;

   // Counter must be able to hold values 0..NDIGITS
   function automatic int cnt_width(input int ndigits);
      return $clog2(ndigits + 1);
   endfunction

endpackage

// File: rtl/i4004_digit_adder.sv
// Single-digit adder: binary or decimal-adjusted, with optional complement of B.
// Latency: combinational (0 cycles).
// Backpressure: none, pure function of its inputs.
module i4004_digit_adder
   import i4004_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic [DW-1:0] ad,
   input  logic [DW-1:0] bd,
   input  logic          c,
   input  logic          bcd,
   input  logic          sub,
   output logic [DW-1:0] digit,
   output logic          carry
);

   // Binary path: ones-complement of B for subtract, carry acts as not-borrow
   logic [DW-1:0] bd_bin;
   logic [DW:0]   raw_bin;

   assign bd_bin  = sub ? ~bd : bd;
   assign raw_bin = {1'b0, ad} + {1'b0, bd_bin} + {{DW{1'b0}}, c};

   generate
      if (DW == 4) begin : g_bcd
         logic [3:0] bd_dec;
         logic [4:0] raw_dec;
         logic [3:0] adj;

         // Nines-complement of B wraps mod 16 so non-decimal digits stay deterministic
         assign bd_dec  = sub ? (4'(BCD_MAX) - bd) : bd;
         assign raw_dec = {1'b0, ad} + {1'b0, bd_dec} + {4'b0000, c};
         assign adj     = raw_dec[3:0] + 4'(BCD_ADJ);

         // Select decimal-adjusted or plain binary result for this digit
         always_comb begin
            digit = raw_bin[3:0];
            carry = raw_bin[4];
            if (bcd) begin
               if (raw_dec > 5'(BCD_MAX)) begin
                  digit = adj;
                  carry = 1'b1;
               end else begin
                  digit = raw_dec[3:0];
                  carry = 1'b0;
               end
            end
         end
      end else begin : g_bin
         // Decimal mode only makes sense for 4-bit digits; the flag is dropped here
         logic unused_bcd;
         assign unused_bcd = bcd;
         assign digit      = raw_bin[DW-1:0];
         assign carry      = raw_bin[DW];
      end
   endgenerate

endmodule

// File: rtl/i4004_serial_adder.sv
// Digit-serial add/subtract over NDIGITS digits, least-significant digit first.
// Latency: done pulses NDIGITS+1 cycles after the accepting start edge.
// Backpressure: start is ignored while busy; accepted in IDLE or on the done cycle.
module i4004_serial_adder
   import i4004_pkg::*;
#(
   parameter int NDIGITS = 4,
   parameter int DW      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode_bcd,
   input  logic                  sub,
   input  logic                  cin,
   input  logic [NDIGITS*DW-1:0] a,
   input  logic [NDIGITS*DW-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [NDIGITS*DW-1:0] sum,
   output logic                  cout,
   output logic                  zero
);

   localparam int             W    = NDIGITS * DW;
   localparam int             CW   = cnt_width(NDIGITS);
   localparam logic [CW-1:0]  LAST = CW'(NDIGITS - 1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  acc_q;
   logic [W-1:0]  acc_d;
   logic          carry_q;
   logic          bcd_q;
   logic          sub_q;
   logic          busy_q;
   logic          done_q;
   logic [W-1:0]  sum_q;
   logic          cout_q;
   logic          zero_q;

   logic [DW-1:0] digit;
   logic          dcarry;

   i4004_digit_adder #(
      .DW (DW)
   ) u_digit (
      .ad    (a_q[DW-1:0]),
      .bd    (b_q[DW-1:0]),
      .c     (carry_q),
      .bcd   (bcd_q),
      .sub   (sub_q),
      .digit (digit),
      .carry (dcarry)
   );

   // New digit enters at the top; after NDIGITS shifts digit 0 sits at the bottom
   assign acc_d = W'({digit, acc_q} >> DW);

   // Sequencer, operand/result shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         bcd_q   <= 1'b0;
         sub_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  bcd_q   <= mode_bcd;
                  sub_q   <= sub;
                  carry_q <= sub ? ~cin : cin;
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q     <= a_q >> DW;
               b_q     <= b_q >> DW;
               acc_q   <= acc_d;
               carry_q <= dcarry;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  // Publish result, carry and zero flag together with done
                  sum_q   <= acc_d;
                  cout_q  <= dcarry;
                  zero_q  <= (acc_d == '0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_i4004_serial_adder.sv
// Bench for the digit-serial adder: directed cases, handshake, reset abort,
// and randomized parameter sweep against a word/digit-level reference model.
module tb_i4004_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        mode_bcd;
   logic        sub;
   logic        cin;
   logic [31:0] a;
   logic [31:0] b;
   int          sel;

   always #5 clk = ~clk;

   logic [3:0] st;
   always_comb begin
      st = 4'b0000;
      st[sel[1:0]] = start;
   end

   logic busy0, done0, cout0, zero0; logic [15:0] sum0;
   logic busy1, done1, cout1, zero1; logic [3:0]  sum1;
   logic busy2, done2, cout2, zero2; logic [31:0] sum2;
   logic busy3, done3, cout3, zero3; logic [31:0] sum3;

   i4004_serial_adder #(.NDIGITS(4), .DW(4)) u0 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .mode_bcd(mode_bcd), .sub(sub), .cin(cin),
      .a(a[15:0]), .b(b[15:0]), .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .zero(zero0));
   i4004_serial_adder #(.NDIGITS(1), .DW(4)) u1 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .mode_bcd(mode_bcd), .sub(sub), .cin(cin),
      .a(a[3:0]), .b(b[3:0]), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .zero(zero1));
   i4004_serial_adder #(.NDIGITS(8), .DW(4)) u2 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .mode_bcd(mode_bcd), .sub(sub), .cin(cin),
      .a(a), .b(b), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .zero(zero2));
   i4004_serial_adder #(.NDIGITS(4), .DW(8)) u3 (
      .clk(clk), .rst_n(rst_n), .start(st[3]), .mode_bcd(mode_bcd), .sub(sub), .cin(cin),
      .a(a), .b(b), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .zero(zero3));

   logic        o_busy, o_done, o_cout, o_zero;
   logic [31:0] o_sum;
   always_comb begin
      o_busy = busy0; o_done = done0; o_cout = cout0; o_zero = zero0; o_sum = {16'h0, sum0};
      case (sel)
         1: begin o_busy = busy1; o_done = done1; o_cout = cout1; o_zero = zero1; o_sum = {28'h0, sum1}; end
         2: begin o_busy = busy2; o_done = done2; o_cout = cout2; o_zero = zero2; o_sum = sum2; end
         3: begin o_busy = busy3; o_done = done3; o_cout = cout3; o_zero = zero3; o_sum = sum3; end
         default: ;
      endcase
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int nd_of(input int s);
      case (s)
         1: return 1;
         2: return 8;
         default: return 4;
      endcase
   endfunction

   function automatic int dw_of(input int s);
      return (s == 3) ? 8 : 4;
   endfunction

   // Reference: binary as whole-word integer arithmetic, BCD digit by digit
   function automatic void model(input int nd, input int dw, input bit bcd, input bit sb, input bit ci,
                                 input logic [31:0] aa, input logic [31:0] bb,
                                 output logic [31:0] s, output bit co);
      int          w;
      logic [63:0] m, ua, ub, t;
      int          c, ad, bd, be, x;
      w  = nd * dw;
      m  = (64'd1 << w) - 64'd1;
      ua = {32'h0, aa} & m;
      ub = {32'h0, bb} & m;
      s  = '0;
      co = 1'b0;
      if (bcd && dw == 4) begin
         c = sb ? int'(!ci) : int'(ci);
         for (int i = 0; i < nd; i++) begin
            ad = int'((ua >> (4 * i)) & 64'hF);
            bd = int'((ub >> (4 * i)) & 64'hF);
            be = sb ? ((9 - bd) & 15) : bd;
            x  = ad + be + c;
            if (x > 9) begin x = (x + 6) & 15; c = 1; end
            else c = 0;
            s[4 * i +: 4] = 4'(x);
         end
         co = (c != 0);
      end else if (!sb) begin
         t  = ua + ub + {63'h0, ci};
         s  = 32'(t & m);
         co = t[w];
      end else begin
         t  = ua - ub - {63'h0, ci};
         s  = 32'(t & m);
         co = (ua >= ub + {63'h0, ci});
      end
   endfunction

   function automatic logic [31:0] rand_op(input int nd, input int dw, input bit dec);
      logic [31:0] v;
      logic [63:0] m;
      m = (64'd1 << (nd * dw)) - 64'd1;
      v = '0;
      if (dec && dw == 4) begin
         for (int i = 0; i < nd; i++) v[4 * i +: 4] = 4'($urandom_range(0, 9));
      end else begin
         v = $urandom;
      end
      return v & m[31:0];
   endfunction

   task automatic run_op(input int s, input bit bcd, input bit sb, input bit ci,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input bit use_x, input logic [31:0] xs, input bit xc, input string tag);
      int          nd, dw, done_at, busy_n;
      logic [31:0] es, prev;
      bit          ec, held_ok;
      logic        busy_at_done;
      nd = nd_of(s); dw = dw_of(s);
      done_at = 0; busy_n = 0; busy_at_done = 1'b0; held_ok = 1'b1; prev = '0;
      if (use_x) begin es = xs; ec = xc; end
      else model(nd, dw, bcd, sb, ci, aa, bb, es, ec);
      @(negedge clk);
      sel = s; mode_bcd = bcd; sub = sb; cin = ci; a = aa; b = bb; start = 1'b1;
      for (int k = 1; k <= nd + 4; k++) begin
         @(negedge clk);
         if (k == 1) begin start = 1'b0; prev = o_sum; end
         if (o_done) begin done_at = k; busy_at_done = o_busy; break; end
         if (o_busy) busy_n++;
         if (o_sum !== prev) held_ok = 1'b0;
      end
      if (done_at == 0) begin
         check({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         check({tag, "_sum"}, 64'(o_sum), 64'(es));
         check({tag, "_cout"}, 64'(o_cout), 64'(ec));
         check({tag, "_zero"}, 64'(o_zero), 64'(es == 32'h0));
         check({tag, "_lat"}, 64'(done_at), 64'(nd + 1));
         check({tag, "_busycyc"}, 64'(busy_n), 64'(nd));
         check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
         check({tag, "_held"}, 64'(held_ok), 64'd1);
         @(negedge clk);
         check({tag, "_pulse"}, 64'(o_done), 64'd0);
      end
   endtask

   logic [31:0] ha [0:20];
   logic [31:0] hb [0:20];
   bit          hbcd [0:20];
   bit          hsub [0:20];
   bit          hcin [0:20];

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      logic [31:0] es;
      bit          ec;
      int          dcount, done_at;
      rst_n = 1'b0; start = 1'b0; mode_bcd = 1'b0; sub = 1'b0; cin = 1'b0;
      a = '0; b = '0; sel = 0;
      #2;
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_sum",  64'(o_sum),  64'd0);
      check("rst_cout", 64'(o_cout), 64'd0);
      check("rst_zero", 64'(o_zero), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      run_op(0, 1'b0, 1'b0, 1'b0, 32'hFFFF, 32'h0001, 1'b1, 32'h0000, 1'b1, "bin_add_wrap");
      run_op(0, 1'b1, 1'b0, 1'b0, 32'h0999, 32'h0001, 1'b1, 32'h1000, 1'b0, "bcd_add_ripple");
      run_op(0, 1'b1, 1'b0, 1'b0, 32'h9999, 32'h0001, 1'b1, 32'h0000, 1'b1, "bcd_add_ovf");
      run_op(0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h0001, 1'b1, 32'h0999, 1'b1, "bcd_sub");
      run_op(0, 1'b1, 1'b1, 1'b0, 32'h0000, 32'h0001, 1'b1, 32'h9999, 1'b0, "bcd_sub_borrow");
      run_op(0, 1'b0, 1'b1, 1'b1, 32'h1234, 32'h0234, 1'b1, 32'h0FFF, 1'b1, "bin_sub_bin");
      run_op(3, 1'b1, 1'b0, 1'b0, 32'h0000_0009, 32'h0000_0001, 1'b1, 32'h0000_000A, 1'b0, "dw8_bcd_is_bin");

      // Start pulse while busy must be ignored
      model(4, 4, 1'b0, 1'b0, 1'b1, 32'h1111, 32'h2222, es, ec);
      @(negedge clk);
      sel = 0; mode_bcd = 1'b0; sub = 1'b0; cin = 1'b1; a = 32'h1111; b = 32'h2222; start = 1'b1;
      dcount = 0; done_at = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 2) begin start = 1'b1; a = 32'h5555; b = 32'h7777; sub = 1'b1; mode_bcd = 1'b1; end
         if (k == 3) start = 1'b0;
         if (o_done) begin
            dcount++;
            if (done_at == 0) begin
               done_at = k;
               check("ign_sum", 64'(o_sum), 64'(es));
               check("ign_cout", 64'(o_cout), 64'(ec));
            end
         end
      end
      check("ign_lat", 64'(done_at), 64'd5);
      check("ign_ndone", 64'(dcount), 64'd1);

      // Continuous start: acceptance every NDIGITS+1 cycles, sampling those cycles' operands
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         if (k > 0) begin
            check("hs_done", 64'(o_done), 64'(k % 5 == 0));
            check("hs_busy", 64'(o_busy), 64'(k % 5 != 0));
            if (k % 5 == 0) begin
               model(4, 4, hbcd[k-5], hsub[k-5], hcin[k-5], ha[k-5], hb[k-5], es, ec);
               check("hs_sum", 64'(o_sum), 64'(es));
               check("hs_cout", 64'(o_cout), 64'(ec));
            end
         end
         hbcd[k] = 1'($urandom); hsub[k] = 1'($urandom); hcin[k] = 1'($urandom);
         ha[k] = rand_op(4, 4, hbcd[k]); hb[k] = rand_op(4, 4, hbcd[k]);
         sel = 0; mode_bcd = hbcd[k]; sub = hsub[k]; cin = hcin[k]; a = ha[k]; b = hb[k];
         start = (k < 20);
      end

      // Reset in the middle of RUN aborts with no done
      run_op(0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1111, 1'b1, 32'h2345, 1'b0, "pre_rst");
      @(negedge clk);
      sel = 0; mode_bcd = 1'b0; sub = 1'b0; cin = 1'b0; a = 32'h0F0F; b = 32'h0101; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(o_busy), 64'd0);
      check("abort_done", 64'(o_done), 64'd0);
      check("abort_sum",  64'(o_sum),  64'd0);
      check("abort_cout", 64'(o_cout), 64'd0);
      check("abort_zero", 64'(o_zero), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (o_done) dcount++;
      end
      check("abort_nodone", 64'(dcount), 64'd0);
      run_op(0, 1'b1, 1'b0, 1'b1, 32'h0458, 32'h0543, 1'b1, 32'h1002, 1'b0, "post_rst");

      // Randomized sweep over all configurations
      for (int s = 0; s < 4; s++) begin
         for (int n = 0; n < ((s == 0) ? 200 : 1000); n++) begin
            bit rb, rs, rc, dec;
            rb  = 1'($urandom);
            rs  = 1'($urandom);
            rc  = 1'($urandom);
            dec = 1'($urandom);
            run_op(s, rb, rs, rc, rand_op(nd_of(s), dw_of(s), dec), rand_op(nd_of(s), dw_of(s), dec),
                   1'b0, 32'h0, 1'b0, $sformatf("rnd_s%0d", s));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i4004_serial_adder.md
Name: i4004_serial_adder

Overview:
Parametrised digit-serial adder/subtractor for the i4004 datapath: the successor to the combinational 8-bit add at the TT top level.
- Operates on NDIGITS digits of DW bits each, least-significant digit first, one digit per clock.
- Supports binary or BCD (decimal-adjusted) mode, add or subtract, and carry/borrow chaining.
- Sits between the TT pin wrapper and the accumulator/register file. Uses a start/busy/done handshake.

Parameters:
NDIGITS, 4, number of digits per operand (>=1)
DW, 4, bits per digit; BCD mode honoured only when DW==4, otherwise mode_bcd is ignored (binary)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request operation; accepted only when busy==0
mode_bcd  in  1  1=BCD digit arithmetic, 0=binary; sampled with start
sub  in  1  1=a-b, 0=a+b; sampled with start
cin  in  1  add: carry-in; sub: borrow-in (1=borrow); sampled with start
a  in  NDIGITS*DW  operand A, sampled with start
b  in  NDIGITS*DW  operand B, sampled with start
busy  out  1  high while digits are being processed
done  out  1  one-cycle pulse when result is valid
sum  out  NDIGITS*DW  result; valid from done, held until next accepted start
cout  out  1  add: carry-out; sub: 1=no borrow, 0=borrow; held like sum
zero  out  1  sum==0, updated with done, held like sum

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, cout, zero = 0; sum = 0; internal operand/carry registers = 0.
- States are IDLE, RUN and DONE.
  - IDLE: start=1 latches a, b, mode, sub; sets carry0 = sub ? ~cin : cin; digit counter = 0; goes to RUN.
  - RUN: each cycle processes digit[cnt]. Stays for exactly NDIGITS cycles, then goes to DONE.
  - DONE: done=1 for one cycle. Returns to IDLE, or goes straight to RUN if start=1 that cycle (back-to-back accept).
- Latency: start sampled at edge E0. busy is high for edges E1..E(NDIGITS). done is high in the cycle after the final digit, i.e. NDIGITS+1 cycles after the start edge.
- busy and done are never high together. start while busy=1 is ignored with no side effects.
- Per-digit arithmetic, with bd' = effective B digit and c = running carry:
  - Binary: bd' = sub ? ~bd : bd. raw = ad + bd' + c (DW+1 bits). Digit = raw[DW-1:0]; next c = raw[DW].
  - BCD: bd' = sub ? (9 - bd) mod 16 : bd. raw = ad + bd' + c (5 bits). If raw > 9: digit = (raw + 6)[3:0] and next c = 1; else digit = raw[3:0] and next c = 0.
  - Non-BCD input digits (>9) are not flagged. The algorithm above is applied mechanically, so the result is deterministic.
- Result digits shift into a holding register. sum, cout and zero become visible together when done is asserted. Partial results are never exposed on sum during RUN.
- cout = final carry, with the same encoding for add and sub.
- Reset mid-RUN aborts the operation: no done pulse, and outputs take their reset values.
- Mode/sub/cin/operand changes during RUN have no effect.

Decomposition:
- Package i4004_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - constants BCD_MAX=9, BCD_ADJ=6;
  - a function computing the digit-counter width as $clog2(NDIGITS+1).
- Sub-module i4004_digit_adder: combinational single-digit add with optional nines-complement and decimal adjust. Inputs: ad, bd, c, bcd, sub. Outputs: digit, carry.
- The top holds the FSM, counter, operand shift registers and result register.

Test Plan:
- Binary add, a=0xFFFF, b=0x0001, cin=0: sum=0x0000, cout=1, zero=1. done exactly 5 cycles after the start edge; busy high for 4 cycles.
- BCD add, a=0x0999, b=0x0001, cin=0: sum=0x1000, cout=0, zero=0. Also a=0x9999, b=0x0001: sum=0x0000, cout=1, zero=1.
- BCD subtract, a=0x1000, b=0x0001, cin=0: sum=0x0999, cout=1 (no borrow). Also a=0x0000, b=0x0001: sum=0x9999, cout=0 (borrow).
- Handshake: start held high continuously with changing operands. Only the values present at each IDLE/DONE acceptance are used; done pulses every 5 cycles. start pulse during busy is ignored.
- Reset mid-op: assert rst_n=0 after 2 RUN cycles. All outputs go to 0 immediately (async), no done pulse. A new start after release gives the correct result.
- Parameter sweep: NDIGITS=1 and NDIGITS=8 with DW=4, plus DW=8 with mode_bcd=1 (must behave as binary). Compare each against a reference model over 1000 random vectors.
